// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the operation encoding, default operand width and requester count.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int REQ_N      = 2;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_LW   = 3'd4,
    OP_SW   = 3'd5,
    OP_BEQ  = 3'd6,
    OP_RSVD = 3'd7
  } alu_op_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: add/sub/and/or with a BEQ-only zero flag; zero latency.
// No state and no flow control; arithmetic wraps modulo 2^DATA_W.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD, OP_LW, OP_SW: result = a + b;
      OP_SUB, OP_BEQ:       result = a - b;
      OP_AND:               result = a & b;
      OP_OR:                result = a | b;
      default:              result = '0;
    endcase
  end

  // Only a branch compare reports zero; a zero-valued SUB does not.
  assign zero = (op == OP_BEQ) && (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters into a 1-entry result register; 1-cycle latency.
// Grants only when the result slot is empty or being drained this cycle; optional grant counters under ALU_ARB_STATS_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REQ_N-1:0]  req_valid,
  output logic [REQ_N-1:0]  req_ready,
  input  alu_op_t           req_op [REQ_N],
  input  logic [DATA_W-1:0] req_a  [REQ_N],
  input  logic [DATA_W-1:0] req_b  [REQ_N],
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1
);

  logic              prio;
  logic              can_accept;
  logic              xfer;
  logic              sel_id;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  assign can_accept = !rsp_valid || rsp_ready;

  always_comb begin
    req_ready = '0;
    if (!reset && can_accept) begin
      case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        2'b11:   req_ready = prio ? 2'b10 : 2'b01;
        default: req_ready = 2'b00;
      endcase
    end
  end

  assign xfer   = |req_ready;
  assign sel_id = req_ready[1];

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .op     (req_op[sel_id]),
    .a      (req_a[sel_id]),
    .b      (req_b[sel_id]),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // A consume and a new transfer in the same cycle simply reload, so there is no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      prio       <= 1'b0;
    end else if (xfer) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= sel_id;
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      prio       <= ~sel_id;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [STAT_W-1:0] cnt0;
  logic [STAT_W-1:0] cnt1;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (req_ready[0] && (cnt0 != '1)) cnt0 <= cnt0 + STAT_W'(1);
      if (req_ready[1] && (cnt1 != '1)) cnt1 <= cnt1 + STAT_W'(1);
    end
  end

  assign grant_cnt0 = cnt0;
  assign grant_cnt1 = cnt1;
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int SAT = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  alu_op_t       req_op [2];
  logic [DW-1:0] req_a  [2];
  logic [DW-1:0] req_b  [2];
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [DW-1:0] rsp_result;
  logic          rsp_zero;
  logic [SW-1:0] grant_cnt0;
  logic [SW-1:0] grant_cnt1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: the held response, who wins the next tie, and grant tallies.
  bit          m_valid;
  bit          m_id;
  bit          m_zero;
  bit          m_prio;
  logic [31:0] m_result;
  int          m_cnt [2];

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW), .STAT_W(SW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  function automatic logic [31:0] ref_alu(int op, logic [31:0] a, logic [31:0] b);
    case (op)
      0, 4, 5: return a + b;
      1, 6:    return a - b;
      2:       return a & b;
      3:       return a | b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [1:0] exp_grant();
    if (reset) return 2'b00;
    if (m_valid && !rsp_ready) return 2'b00;
    if (req_valid == 2'b01) return 2'b01;
    if (req_valid == 2'b10) return 2'b10;
    if (req_valid == 2'b11) return m_prio ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  // Advance one clock and move the model by the same transaction-level rules.
  task automatic tick();
    logic [1:0] g;
    int w;
    g = exp_grant();
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_id = 0; m_zero = 0; m_prio = 0; m_result = '0;
      m_cnt[0] = 0; m_cnt[1] = 0;
    end else if (g != 2'b00) begin
      w        = g[1] ? 1 : 0;
      m_result = ref_alu(int'(req_op[w]), req_a[w], req_b[w]);
      m_zero   = (req_op[w] == OP_BEQ) && (m_result == 32'd0);
      m_valid  = 1;
      m_id     = w[0];
      m_prio   = (w == 0);
`ifdef ALU_ARB_STATS_EN
      if (m_cnt[w] < SAT) m_cnt[w]++;
`endif
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    tick(); tick();
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_zero} !== 3'b000 || rsp_result !== 32'd0) begin
      n_err++; $display("FAIL reset_outputs: got v=%b id=%b z=%b r=%h want all 0", rsp_valid, rsp_id, rsp_zero, rsp_result);
    end
    n_cmp++;
    if (grant_cnt0 !== 4'd0 || grant_cnt1 !== 4'd0) begin
      n_err++; $display("FAIL reset_counters: got %0d/%0d want 0/0", grant_cnt0, grant_cnt1);
    end
    reset = 1'b0; req_valid = 2'b00;
  endtask

  task automatic test_single();
    req_valid = 2'b01; req_op[0] = OP_ADD; req_a[0] = 32'd5; req_b[0] = 32'd7; rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin n_err++; $display("FAIL single_grant: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd12 || rsp_zero !== 1'b0) begin
      n_err++; $display("FAIL single_rsp: got v=%b id=%b r=%0d z=%b want 1/0/12/0", rsp_valid, rsp_id, rsp_result, rsp_zero);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got v=%b want 0", rsp_valid); end
  endtask

  task automatic test_alternate();
    logic [1:0] want;
    do_reset();
    req_valid = 2'b11; rsp_ready = 1'b1;
    req_op[0] = OP_ADD; req_a[0] = 32'd1; req_b[0] = 32'd2;
    req_op[1] = OP_OR;  req_a[1] = 32'd8; req_b[1] = 32'd4;
    for (int i = 0; i < 4; i++) begin
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      n_cmp++;
      if (req_ready !== want) begin n_err++; $display("FAIL alt_grant%0d: got %b want %b", i, req_ready, want); end
      tick();
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_id !== want[1]) begin
        n_err++; $display("FAIL alt_rsp%0d: got v=%b id=%b want 1/%b", i, rsp_valid, rsp_id, want[1]);
      end
    end
    req_valid = 2'b10; req_op[1] = OP_BEQ; req_a[1] = 32'd9; req_b[1] = 32'd9;
    tick();
    n_cmp++;
    if (rsp_result !== 32'd0 || rsp_zero !== 1'b1 || rsp_id !== 1'b1) begin
      n_err++; $display("FAIL beq_zero: got r=%0d z=%b id=%b want 0/1/1", rsp_result, rsp_zero, rsp_id);
    end
    req_op[1] = OP_SUB;
    tick();
    n_cmp++;
    if (rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin
      n_err++; $display("FAIL sub_nozero: got r=%0d z=%b want 0/0", rsp_result, rsp_zero);
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_backpressure();
    req_valid = 2'b01; req_op[0] = OP_OR; req_a[0] = 32'hF0; req_b[0] = 32'h0F; rsp_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      req_valid = 2'b11; req_op[0] = OP_AND; req_a[0] = $urandom; req_b[0] = $urandom;
      req_op[1] = OP_ADD; req_a[1] = 32'd1; req_b[1] = 32'd2;
      #1;
      n_cmp++;
      if (req_ready !== 2'b00) begin n_err++; $display("FAIL bp_ready%0d: got %b want 00", i, req_ready); end
      tick();
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'hFF || rsp_zero !== 1'b0) begin
        n_err++; $display("FAIL bp_hold%0d: got v=%b id=%b r=%h z=%b want 1/0/ff/0", i, rsp_valid, rsp_id, rsp_result, rsp_zero);
      end
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 2'b10) begin n_err++; $display("FAIL bp_release_grant: got %b want 10", req_ready); end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'd3) begin
      n_err++; $display("FAIL bp_no_bubble: got v=%b id=%b r=%0d want 1/1/3", rsp_valid, rsp_id, rsp_result);
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_wrap();
    req_valid = 2'b01; rsp_ready = 1'b1;
    req_op[0] = OP_ADD; req_a[0] = 32'hFFFF_FFFF; req_b[0] = 32'd1;
    tick();
    n_cmp++;
    if (rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin
      n_err++; $display("FAIL add_wrap: got r=%h z=%b want 0/0", rsp_result, rsp_zero);
    end
    req_op[0] = OP_RSVD; req_a[0] = 32'd3; req_b[0] = 32'd4;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin
      n_err++; $display("FAIL reserved_op: got v=%b r=%h z=%b want 1/0/0", rsp_valid, rsp_result, rsp_zero);
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b01; req_op[0] = OP_ADD; req_a[0] = 32'd1; req_b[0] = 32'd1; rsp_ready = 1'b0;
    tick();
    reset = 1'b1; req_valid = 2'b00;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd0) begin
      n_err++; $display("FAIL midreset_clear: got v=%b r=%h want 0/0", rsp_valid, rsp_result);
    end
    req_valid = 2'b11;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin n_err++; $display("FAIL midreset_prio: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00; rsp_ready = 1'b1;
    tick();
  endtask

  task automatic test_stats();
    int want0;
`ifdef ALU_ARB_STATS_EN
    want0 = SAT;
`else
    want0 = 0;
`endif
    do_reset();
    req_valid = 2'b01; rsp_ready = 1'b1; req_op[0] = OP_ADD;
    for (int i = 0; i < 20; i++) begin
      req_a[0] = $urandom; req_b[0] = $urandom;
      tick();
    end
    req_valid = 2'b00;
    tick();
    n_cmp++;
    if (int'(grant_cnt0) !== want0 || grant_cnt1 !== 4'd0) begin
      n_err++; $display("FAIL stats_sat: got %0d/%0d want %0d/0", grant_cnt0, grant_cnt1, want0);
    end
  endtask

  task automatic test_random();
    logic [1:0] want;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 2; k++) begin
        req_op[k] = alu_op_t'($urandom_range(0, 7));
        req_a[k]  = $urandom;
        req_b[k]  = ($urandom_range(0, 3) == 0) ? req_a[k] : $urandom;
      end
      #1;
      want = exp_grant();
      n_cmp++;
      if (req_ready !== want) begin n_err++; $display("FAIL rnd_grant@%0d: got %b want %b", i, req_ready, want); end
      tick();
      n_cmp++;
      if (rsp_valid !== m_valid || rsp_id !== m_id || rsp_result !== m_result || rsp_zero !== m_zero) begin
        n_err++; $display("FAIL rnd_rsp@%0d: got v=%b id=%b r=%h z=%b want %b/%b/%h/%b",
                          i, rsp_valid, rsp_id, rsp_result, rsp_zero, m_valid, m_id, m_result, m_zero);
      end
      n_cmp++;
      if (int'(grant_cnt0) !== m_cnt[0] || int'(grant_cnt1) !== m_cnt[1]) begin
        n_err++; $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d/%0d", i, grant_cnt0, grant_cnt1, m_cnt[0], m_cnt[1]);
      end
    end
    reset = 1'b0; req_valid = 2'b00;
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_op[k] = OP_ADD; req_a[k] = '0; req_b[k] = '0;
    end
    m_valid = 0; m_id = 0; m_zero = 0; m_prio = 0; m_result = '0;
    m_cnt[0] = 0; m_cnt[1] = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_stats();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
